// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported 16-bit memory between an instruction-fetch port (I,
//   read-only) and a data port (D, read/write). Round-robin arbitration, request
//   latching, and one idle recovery cycle after every memory response.
//
// Ports
//   clk, reset_n                          clock, asynchronous active-low reset
//   i_read, i_address                     I-port request (held until i_resp)
//   i_resp, i_rdata                       I-port completion pulse and read data
//   d_read, d_write, d_byte_enable,
//   d_address, d_wdata                    D-port request (held until d_resp)
//   d_resp, d_rdata                       D-port completion pulse and read data
//   mem_read, mem_write, mem_byte_enable,
//   mem_address, mem_wdata                memory command (registered)
//   mem_resp, mem_rdata                   memory completion pulse and read data
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [BE_W-1:0]   d_byte_enable,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byte_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RECOVER
  } state_t;

  state_t state;

  // 1 when the most recent grant went to D; reset to I so the first tie goes to D.
  logic last_grant_d;

  logic req_i;
  logic req_d;
  logic arb_window;
  logic grant_i;
  logic grant_d;

  assign req_i      = i_read;
  assign req_d      = d_read | d_write;
  assign arb_window = (state == IDLE) || (state == RECOVER);

  // On a tie, the port that did not win last time gets the memory.
  assign grant_d = arb_window & req_d & (~req_i | ~last_grant_d);
  assign grant_i = arb_window & req_i & ~grant_d;

  // Responses are a combinational pass-through of the memory pulse, steered by
  // the owner of the current transfer. Stray pulses outside BUSY are dropped.
  assign i_resp  = (state == BUSY_I) & mem_resp;
  assign d_resp  = (state == BUSY_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  // The memory command registers double as the request latch: they are loaded
  // at the grant edge and held untouched until the memory responds, so the
  // requester may change its inputs freely while the transfer is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_grant_d    <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE, RECOVER: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (grant_d) begin
            state           <= BUSY_D;
            last_grant_d    <= 1'b1;
            mem_write       <= d_write;
            mem_read        <= d_read & ~d_write;
            mem_byte_enable <= d_byte_enable;
            mem_address     <= d_address;
            mem_wdata       <= d_wdata;
          end else if (grant_i) begin
            state           <= BUSY_I;
            last_grant_d    <= 1'b0;
            mem_read        <= 1'b1;
            mem_byte_enable <= {BE_W{1'b1}};
            mem_address     <= i_address;
            mem_wdata       <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          // Dropping the strobes here gives the memory one quiet cycle to
          // leave its respond state before the next command.
          if (mem_resp) begin
            state     <= RECOVER;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A behavioural memory answers commands
//   after a configurable or random latency, two port agents replay queued
//   requests, and a transfer-level reference model predicts grants, bus
//   contents, response steering and read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [1:0]  d_byte_enable = '0;
  logic [15:0] d_address = '0;
  logic [15:0] d_wdata = '0;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by the DUT, and the bench's own expectation of them.
  logic [15:0] mem_words [0:32767];
  logic [15:0] ref_words [0:32767];
  int mem_lat = -1;
  int mcnt = -1;
  bit stray_pulse = 1'b0;

  // Behavioural memory: responds with a one-cycle pulse, latency mem_lat
  // cycles (random 0..2 when mem_lat is negative).
  always @(negedge clk) begin
    if (mem_resp) begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
    end else if (stray_pulse) begin
      stray_pulse = 1'b0;
      mem_resp    = 1'b1;
      mem_rdata   = 16'hDEAD;
    end else if (mem_read || mem_write) begin
      if (mcnt < 0) mcnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 2));
      if (mcnt == 0) begin
        if (mem_write) begin
          if (mem_byte_enable[0]) mem_words[mem_address[15:1]][7:0]  = mem_wdata[7:0];
          if (mem_byte_enable[1]) mem_words[mem_address[15:1]][15:8] = mem_wdata[15:8];
        end else begin
          mem_rdata = mem_words[mem_address[15:1]];
        end
        mem_resp = 1'b1;
        mcnt = -1;
      end else begin
        mcnt--;
      end
    end else begin
      mcnt = -1;
    end
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } d_txn_t;

  logic [15:0] i_q[$];
  d_txn_t      d_q[$];
  bit i_active = 1'b0, i_done = 1'b0;
  bit d_active = 1'b0, d_done = 1'b0;

  // Port agents: present the next queued request and hold it until the
  // response has been observed.
  always @(negedge clk) begin
    if (i_done) begin
      i_done = 1'b0; i_active = 1'b0; i_read = 1'b0;
    end
    if (reset_n && !i_active && i_q.size() > 0) begin
      i_address = i_q.pop_front();
      i_read = 1'b1;
      i_active = 1'b1;
    end
  end

  always @(negedge clk) begin
    d_txn_t t;
    if (d_done) begin
      d_done = 1'b0; d_active = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    if (reset_n && !d_active && d_q.size() > 0) begin
      t = d_q.pop_front();
      d_read = t.rd; d_write = t.wr; d_address = t.addr;
      d_wdata = t.wdata; d_byte_enable = t.be;
      d_active = 1'b1;
    end
  end

  // Reference model, one step per cycle. P_DONE marks the response cycle and
  // P_RECOV the mandatory quiet cycle that follows it.
  typedef enum {P_FREE, P_XFER, P_DONE, P_RECOV} phase_t;
  phase_t ph = P_FREE;
  bit model_last_d = 1'b0;
  logic p_i_read = 1'b0, p_d_read = 1'b0, p_d_write = 1'b0;
  logic [15:0] p_i_addr = '0, p_d_addr = '0, p_d_wdata = '0;
  logic [1:0]  p_d_be = '0;
  bit x_is_d = 1'b0, x_rd = 1'b0, x_wr = 1'b0;
  logic [15:0] x_addr = '0, x_wdata = '0;
  logic [1:0]  x_be = '0;
  int n_i_done = 0, n_d_done = 0;
  byte grant_log[$];
  logic [15:0] last_i_rdata = '0, last_d_rdata = '0;
  int low_run = 0, last_gap = -1;
  bit prev_strobe = 1'b0;
  event sampled;

  always @(negedge clk) begin
    logic [15:0] exp_data;
    #1;
    if (!reset_n) begin
      ph = P_FREE;
      model_last_d = 1'b0;
      low_run = 0;
      prev_strobe = 1'b0;
    end else begin
      case (ph)
        P_FREE, P_RECOV: begin
          if (p_i_read || p_d_read || p_d_write) begin
            x_is_d = (p_d_read || p_d_write) && (!p_i_read || !model_last_d);
            model_last_d = x_is_d;
            if (x_is_d) begin
              x_wr = p_d_write; x_rd = p_d_read && !p_d_write;
              x_addr = p_d_addr; x_wdata = p_d_wdata; x_be = p_d_be;
              grant_log.push_back("D");
            end else begin
              x_wr = 1'b0; x_rd = 1'b1; x_addr = p_i_addr; x_be = 2'b11;
              grant_log.push_back("I");
            end
            ph = P_XFER;
          end else begin
            ph = P_FREE;
          end
        end
        P_DONE:  ph = P_RECOV;
        default: ;
      endcase

      if (ph == P_XFER) begin
        check_output("mem_read", mem_read, x_rd);
        check_output("mem_write", mem_write, x_wr);
        check_output("mem_address", mem_address, x_addr);
        check_output("mem_byte_enable", mem_byte_enable, x_be);
        if (x_is_d) check_output("mem_wdata", mem_wdata, x_wdata);
        if (mem_resp) begin
          check_output("resp_steer", {i_resp, d_resp}, x_is_d ? 2'b01 : 2'b10);
          if (x_wr) begin
            if (x_be[0]) ref_words[x_addr[15:1]][7:0]  = x_wdata[7:0];
            if (x_be[1]) ref_words[x_addr[15:1]][15:8] = x_wdata[15:8];
          end else begin
            exp_data = ref_words[x_addr[15:1]];
            check_output(x_is_d ? "d_rdata" : "i_rdata", x_is_d ? d_rdata : i_rdata, exp_data);
          end
          ph = P_DONE;
        end else begin
          check_output("resp_busy", {i_resp, d_resp}, 2'b00);
        end
      end else begin
        check_output("strobes_quiet", {mem_read, mem_write}, 2'b00);
        check_output("resp_quiet", {i_resp, d_resp}, 2'b00);
      end

      if (i_resp) begin i_done = 1'b1; n_i_done++; last_i_rdata = i_rdata; end
      if (d_resp) begin d_done = 1'b1; n_d_done++; last_d_rdata = d_rdata; end

      if (mem_read || mem_write) begin
        if (!prev_strobe) last_gap = low_run;
        low_run = 0;
        prev_strobe = 1'b1;
      end else begin
        low_run++;
        prev_strobe = 1'b0;
      end
    end
    p_i_read = i_read; p_i_addr = i_address;
    p_d_read = d_read; p_d_write = d_write;
    p_d_addr = d_address; p_d_wdata = d_wdata; p_d_be = d_byte_enable;
    -> sampled;
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_strobes"}, {mem_read, mem_write}, 2'b00);
    check_output({tag, "_be"}, mem_byte_enable, 2'b00);
    check_output({tag, "_addr"}, mem_address, 16'h0000);
    check_output({tag, "_wdata"}, mem_wdata, 16'h0000);
    check_output({tag, "_resp"}, {i_resp, d_resp}, 2'b00);
    check_output({tag, "_rdata"}, {i_rdata, d_rdata}, 32'h0);
  endtask

  task automatic clear_agents();
    i_q.delete(); d_q.delete();
    i_active = 1'b0; i_done = 1'b0; i_read = 1'b0;
    d_active = 1'b0; d_done = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_agents();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic apply_stimulus(input bit is_d, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [1:0] be);
    d_txn_t t;
    if (is_d) begin
      t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be;
      d_q.push_back(t);
    end else begin
      i_q.push_back(addr);
    end
  endtask

  task automatic wait_done(input string tag, input int i_target, input int d_target, input int budget);
    int n = 0;
    while ((n_i_done < i_target || n_d_done < d_target) && n < budget) begin
      @(sampled);
      n++;
    end
    check_output({tag, "_timeout"}, (n_i_done >= i_target && n_d_done >= d_target), 1'b1);
  endtask

  task automatic wait_xfer(input string tag, input bit want_d, input int budget);
    int n = 0;
    while (!(ph == P_XFER && x_is_d == want_d) && n < budget) begin
      @(sampled);
      n++;
    end
    check_output({tag, "_timeout"}, (ph == P_XFER && x_is_d == want_d), 1'b1);
  endtask

  initial begin
    int bi, bd, pi, pd;
    for (int k = 0; k < 32768; k++) begin
      mem_words[k] = '0;
      ref_words[k] = '0;
    end
    mem_words[16'h0010 >> 1] = 16'h1234; ref_words[16'h0010 >> 1] = 16'h1234;
    mem_words[16'h0020 >> 1] = 16'h5566; ref_words[16'h0020 >> 1] = 16'h5566;
    mem_words[16'h0030 >> 1] = 16'h9ABC; ref_words[16'h0030 >> 1] = 16'h9ABC;

    // Reset values
    #2 check_all_zero("reset");
    apply_reset();

    // Single fetch
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    wait_done("fetch", 1, 0, 100);
    check_output("fetch_rdata", last_i_rdata, 16'h1234);
    check_output("fetch_no_d_resp", n_d_done, 0);

    // Upper-byte write then readback
    mem_lat = 1;
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'h0021, 16'hABCD, 2'b10);
    wait_done("write", 1, 1, 100);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b11);
    wait_done("readback", 1, 2, 100);
    check_output("readback_rdata", last_d_rdata, 16'hAB66);
    check_output("mem_word_0020", mem_words[16'h0020 >> 1], 16'hAB66);

    // Simultaneous first requests after reset: D wins, one quiet cycle, then I
    mem_lat = 0;
    apply_reset();
    grant_log.delete();
    bi = n_i_done; bd = n_d_done;
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 2'b11);
    wait_done("tie", bi + 1, bd + 1, 100);
    check_output("tie_first", grant_log.size() > 0 ? grant_log[0] : 8'h0, "D");
    check_output("tie_second", grant_log.size() > 1 ? grant_log[1] : 8'h0, "I");
    check_output("tie_gap", last_gap, 1);

    // Continuous contention alternates strictly
    mem_lat = -1;
    grant_log.delete();
    bi = n_i_done; bd = n_d_done;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'(16'h0040 + 2 * k), 16'h0, 2'b00);
      apply_stimulus(1'b1, 1'b1, 1'b0, 16'(16'h0050 + 2 * k), 16'h0, 2'b11);
    end
    wait_done("alt", bi + 3, bd + 3, 200);
    check_output("alt_len", grant_log.size(), 6);
    for (int k = 0; k < 6; k++)
      check_output($sformatf("alt_%0d", k), grant_log.size() > k ? grant_log[k] : 8'h0,
                   (k % 2 == 0) ? "D" : "I");

    // Reset during a D transfer, then a stray memory pulse
    mem_lat = 6;
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'h0060, 16'h1111, 2'b11);
    wait_xfer("abort", 1'b1, 100);
    #1 reset_n = 1'b0;
    #1 check_all_zero("abort");
    clear_agents();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    bi = n_i_done; bd = n_d_done;
    stray_pulse = 1'b1;
    repeat (4) @(sampled);
    check_output("stray_d", n_d_done, bd);
    check_output("stray_i", n_i_done, bi);
    mem_lat = -1;
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    wait_done("post_abort", bi + 1, bd, 100);
    check_output("post_abort_rdata", last_i_rdata, 16'h1234);

    // Address change while the transfer is in flight
    mem_lat = 4;
    bd = n_d_done;
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 2'b11);
    wait_xfer("hold", 1'b1, 100);
    d_address = 16'h7777;
    @(sampled);
    check_output("hold_addr", mem_address, 16'h0030);
    wait_done("hold", n_i_done, bd + 1, 100);
    check_output("hold_rdata", last_d_rdata, 16'h9ABC);

    // Fetch request withdrawn mid-transfer still completes
    mem_lat = 3;
    bi = n_i_done;
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    wait_xfer("drop", 1'b0, 100);
    i_read = 1'b0;
    wait_done("drop", bi + 1, n_d_done, 100);
    check_output("drop_rdata", last_i_rdata, 16'h1234);

    // Random mixed traffic
    mem_lat = -1;
    bi = n_i_done; bd = n_d_done; pi = 0; pd = 0;
    for (int k = 0; k < 40; k++) begin
      int op;
      if ($urandom_range(0, 1) == 0) begin
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 63)), 16'h0, 2'b00);
        pi++;
      end else begin
        op = int'($urandom_range(0, 3));
        apply_stimulus(1'b1, op < 2 || op == 3, op >= 2, 16'($urandom_range(0, 63)),
                       16'($urandom), 2'($urandom_range(1, 3)));
        pd++;
      end
      repeat ($urandom_range(0, 3)) @(sampled);
    end
    wait_done("random", bi + pi, bd + pd, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
